gray_delay_line: RTL



---
 rtl/gray_delay_pkg.sv | 36 +++
 rtl/gray_dpram.sv | 27 ++
 rtl/gray_delay_line.sv | 112 +++++++++++
 3 files changed

// File: rtl/gray_delay_pkg.sv
// Shared luma weights, fill-state encoding and the RGB565-to-gray conversion.
// Optional build macro: GRAY_DELAY_ROUND_EN selects rounding (instead of truncation) of the luma sum.
package gray_delay_pkg;

  localparam logic [7:0] LUMA_W_R = 8'd77;
  localparam logic [7:0] LUMA_W_G = 8'd150;
  localparam logic [7:0] LUMA_W_B = 8'd29;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FILLING   = 2'd1,
    STREAMING = 2'd2
  } fillState_t;

  // Channels are widened by bit replication so full-scale inputs map to 255.
  function automatic logic [7:0] rgb565ToGray(input logic [15:0] pix);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
`ifdef GRAY_DELAY_ROUND_EN
    logic [16:0] rounded;
`endif
    r8  = {pix[15:11], pix[15:13]};
    g8  = {pix[10:5], pix[10:9]};
    b8  = {pix[4:0], pix[4:2]};
    sum = 16'(r8) * 16'(LUMA_W_R) + 16'(g8) * 16'(LUMA_W_G) + 16'(b8) * 16'(LUMA_W_B);
`ifdef GRAY_DELAY_ROUND_EN
    rounded = {1'b0, sum} + 17'd128;
    return rounded[16] ? 8'hFF : rounded[15:8];
`else
    return sum[15:8];
`endif
  endfunction

endpackage

// File: rtl/gray_dpram.sv
// 1R1W synchronous RAM, 2**ADDR_W x 8, shared address; a read and write to the
// same address in one cycle returns the old contents.
module gray_dpram #(
  parameter int ADDR_W = 10
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iWe,
  input  logic              iRe,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [7:0]        iWrData,
  output logic [7:0]        oRdData
);

  logic [7:0] mem [2**ADDR_W];

  // Array write kept free of reset so the storage maps onto block RAM.
  always_ff @(posedge iCLK) begin
    if (iWe) mem[iAddr] <= iWrData;
  end

  always_ff @(posedge iCLK) begin
    if (iRST)     oRdData <= 8'd0;
    else if (iRe) oRdData <= mem[iAddr];
  end

endmodule

// File: rtl/gray_delay_line.sv
// RGB565 -> 8-bit luma, delayed by DEPTH accepted pixels through a circular buffer.
// Optional build macro: GRAY_DELAY_ROUND_EN (rounded luma, see gray_delay_pkg).
module gray_delay_line
  import gray_delay_pkg::*;
#(
  parameter int DEPTH  = 800,
  parameter int ADDR_W = 10
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFrameStart,
  input  logic        iValid,
  input  logic [15:0] iData,
  output logic [7:0]  oGray,
  output logic [7:0]  oGrayDelayed,
  output logic        oValid,
  output logic        oPrimed
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  logic              s1Valid;
  logic [7:0]        s1Gray;
  logic              write;
  fillState_t        fillState, fillStateNext;
  logic [ADDR_W:0]   count, countNext;
  logic [ADDR_W-1:0] wptr, wptrNext;

  // Stage 1: conversion. A frame start drops whatever was held and may capture pixel 0.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1Valid <= 1'b0;
      s1Gray  <= 8'd0;
    end else begin
      s1Valid <= iValid;
      if (iValid) s1Gray <= rgb565ToGray(iData);
    end
  end

  assign write = s1Valid && !iFrameStart && !iRST;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fillState <= EMPTY;
      count     <= '0;
      wptr      <= '0;
    end else begin
      fillState <= fillStateNext;
      count     <= countNext;
      wptr      <= wptrNext;
    end
  end

  always_comb begin
    fillStateNext = fillState;
    countNext     = count;
    wptrNext      = wptr;
    if (iFrameStart) begin
      fillStateNext = EMPTY;
      countNext     = '0;
      wptrNext      = '0;
    end else if (write) begin
      wptrNext = (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
      case (fillState)
        EMPTY: begin
          fillStateNext = FILLING;
          countNext     = (ADDR_W + 1)'(1);
        end
        FILLING: begin
          countNext = count + 1'b1;
          if (count == LAST_CNT) fillStateNext = STREAMING;
        end
        STREAMING: countNext = FULL_CNT;
        default: begin
          fillStateNext = EMPTY;
          countNext     = '0;
          wptrNext      = '0;
        end
      endcase
    end
  end

  // Stage 2: oValid only for writes made while already streaming.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oGray  <= 8'd0;
      oValid <= 1'b0;
    end else if (write) begin
      oGray  <= s1Gray;
      oValid <= (fillState == STREAMING);
    end else begin
      oValid <= 1'b0;
    end
  end

  assign oPrimed = (fillState == STREAMING);

  gray_dpram #(
    .ADDR_W (ADDR_W)
  ) uBuffer (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iWe     (write),
    .iRe     (write),
    .iAddr   (wptr),
    .iWrData (s1Gray),
    .oRdData (oGrayDelayed)
  );

endmodule
